// File: rtl/time_display_pkg.sv
// Shared constants and types for the MM.SS multiplexed display.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package time_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] digit_idx_t;

    typedef logic [1:0] conv_state_t;
    localparam conv_state_t ST_IDLE = 2'd0;
    localparam conv_state_t ST_CONV = 2'd1;
    localparam conv_state_t ST_LOAD = 2'd2;

    localparam logic [6:0] MIN_MAX = 7'd99;
    localparam logic [5:0] SEC_MAX = 6'd59;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/time_display_bin2bcd_seq.sv
// Sequential binary-to-BCD converter for clamped minute/second values.
// One subtract-by-10 per cycle; all digits and ovf update together in LOAD.
//
// state | meaning
// IDLE  | waiting for a pending request, snapshots inputs when one exists
// CONV  | subtracting 10 from minutes first, then seconds
// LOAD  | copying the result to the output digit registers
module bin2bcd_seq
    import time_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] minute,
    input  logic [5:0] second,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       ovf,
    output logic       done
);

    conv_state_t state;
    logic        pending;
    logic [6:0]  m;
    logic [5:0]  s;
    logic [3:0]  mt;
    logic [3:0]  st;
    logic        ovf_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= 1'b1;
            m        <= '0;
            s        <= '0;
            mt       <= '0;
            st       <= '0;
            ovf_n    <= 1'b0;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // A request arriving while busy stays latched until the next IDLE.
            pending <= start | (pending & (state != ST_IDLE));
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        m     <= (minute > MIN_MAX) ? MIN_MAX : minute;
                        s     <= (second > SEC_MAX) ? SEC_MAX : second;
                        ovf_n <= (minute > MIN_MAX) | (second > SEC_MAX);
                        mt    <= '0;
                        st    <= '0;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (m >= 7'd10) begin
                        m  <= m - 7'd10;
                        mt <= mt + 4'd1;
                    end else if (s >= 6'd10) begin
                        s  <= s - 6'd10;
                        st <= st + 4'd1;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    min_tens <= mt;
                    min_ones <= m[3:0];
                    sec_tens <= st;
                    sec_ones <= s[3:0];
                    ovf      <= ovf_n;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/time_display.sv
// 4-digit MM.SS multiplexed 7-segment driver with sampled BCD conversion.
// Optional: define TIME_DISPLAY_LEAD_BLANK_EN to blank a leading minute-tens zero.
module time_display
    import time_display_pkg::*;
#(
    parameter int SCAN_DIV = 4000,
    parameter int CW       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] minute,
    input  logic [5:0] second,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       ovf,
    output logic       upd
);

    logic [CW-1:0] presc;
    digit_idx_t    idx;
    logic          tick;
    logic          frame_start;

    logic [3:0]    min_tens;
    logic [3:0]    min_ones;
    logic [3:0]    sec_tens;
    logic [3:0]    sec_ones;
    logic          conv_done;
    logic [16:0]   cur_word;
    logic [16:0]   prev_word;
    logic [3:0]    digit_sel;

    assign tick        = (presc == CW'(SCAN_DIV - 1));
    assign frame_start = tick & (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + CW'(1);
        end
    end

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (frame_start),
        .minute   (minute),
        .second   (second),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .ovf      (ovf),
        .done     (conv_done)
    );

    // prev_word lags one cycle, so on the done cycle it still holds the old display.
    assign cur_word = {ovf, min_tens, min_ones, sec_tens, sec_ones};

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word <= '0;
            upd       <= 1'b0;
        end else begin
            prev_word <= cur_word;
            upd       <= conv_done && (cur_word != prev_word);
        end
    end

    always_comb begin
        digit_sel = sec_ones;
        case (idx)
            2'd0:    digit_sel = sec_ones;
            2'd1:    digit_sel = sec_tens;
            2'd2:    digit_sel = min_ones;
            2'd3:    digit_sel = min_tens;
            default: digit_sel = sec_ones;
        endcase
    end

    always_comb begin
        seg = seg_encode(digit_sel);
`ifdef TIME_DISPLAY_LEAD_BLANK_EN
        if ((idx == 2'd3) && (min_tens == 4'd0)) begin
            seg = SEG_BLANK;
        end
`endif
    end

    assign an = ~(4'b0001 << idx);
    assign dp = (idx != 2'd2);

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display with a fast scan rate (SCAN_DIV=4).
// Expected display contents come from clamped decimal arithmetic on the applied inputs.
module tb_time_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] minute = '0;
    logic [5:0] second = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       ovf;
    logic       upd;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int upd_seen    = 0;

    int disp_m   = 0;
    int disp_s   = 0;
    bit disp_ovf = 1'b0;

    always #5 clk = ~clk;

    time_display #(.SCAN_DIV(4), .CW(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .minute (minute),
        .second (second),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .ovf    (ovf),
        .upd    (upd)
    );

    // Cycles since reset release; the digit slot is (cyc / 4) % 4.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (upd === 1'b1) upd_seen++;
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        case (i)
            0:       return enc(disp_s % 10);
            1:       return enc(disp_s / 10);
            2:       return enc(disp_m % 10);
            default: begin
`ifdef TIME_DISPLAY_LEAD_BLANK_EN
                if (disp_m / 10 == 0) return 7'b1111111;
`endif
                return enc(disp_m / 10);
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame();
        int         i;
        logic [3:0] exp_an;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            i      = (cyc / 4) % 4;
            exp_an = ~(4'b0001 << i);
            chk("an", {28'd0, an}, {28'd0, exp_an});
            chk($sformatf("seg[%0d]", i), {25'd0, seg}, {25'd0, exp_seg(i)});
            chk("dp", {31'd0, dp}, (i == 2) ? 32'd0 : 32'd1);
            chk("ovf", {31'd0, ovf}, {31'd0, disp_ovf});
        end
    endtask

    task automatic wait_frame_start();
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (cyc % 16 == 0) found = 1'b1;
        end
        chk("frame_start_timeout", {31'd0, found}, 32'd1);
    endtask

    task automatic apply(input int m, input int s);
        int nm, ns, base;
        bit novf, changed;
        @(negedge clk);
        minute  = 7'(m);
        second  = 6'(s);
        base    = upd_seen;
        nm      = (m > 99) ? 99 : m;
        ns      = (s > 59) ? 59 : s;
        novf    = (m > 99) || (s > 59);
        changed = (nm != disp_m) || (ns != disp_s) || (novf != disp_ovf);
        wait_frame_start();
        repeat (24) @(posedge clk);
        disp_m   = nm;
        disp_s   = ns;
        disp_ovf = novf;
        check_frame();
        chk($sformatf("upd_count(%0d,%0d)", m, s), 32'(upd_seen - base), changed ? 32'd1 : 32'd0);
    endtask

    initial begin
        int base;
        rst    = 1'b1;
        minute = 7'd0;
        second = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",  {28'd0, an},  32'b1110);
        chk("rst_seg", {25'd0, seg}, 32'b1000000);
        chk("rst_dp",  {31'd0, dp},  32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_upd", {31'd0, upd}, 32'd0);

        @(negedge clk);
        rst  = 1'b0;
        base = upd_seen;
        check_frame();
        check_frame();
        chk("upd_after_reset_zero", 32'(upd_seen - base), 32'd0);

        apply(25, 39);
        apply(120, 63);
        apply(5, 7);
        apply(5, 7);
        apply(15, 0);
        apply(99, 59);
        apply(100, 10);
        apply(0, 60);

        for (int r = 0; r < 8; r++) begin
            apply(int'($urandom_range(0, 127)), int'($urandom_range(0, 63)));
        end
        apply(5, 7);

        // Reset in the middle of a 99.59 conversion.
        @(negedge clk);
        minute = 7'd99;
        second = 6'd59;
        wait_frame_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_an",  {28'd0, an},  32'b1110);
        chk("midrst_seg", {25'd0, seg}, 32'b1000000);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        chk("midrst_upd", {31'd0, upd}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        base     = upd_seen;
        disp_m   = 99;
        disp_s   = 59;
        disp_ovf = 1'b0;
        repeat (24) @(posedge clk);
        check_frame();
        chk("upd_after_midrst", 32'(upd_seen - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_display.md
Name: time_display

Overview:
- Read-side consumer of the countdown timer's minute/second outputs; drives a 4-digit multiplexed 7-segment display, laid out as MM.SS.
- Samples the binary minute/second values once per refresh frame.
- Converts them to BCD with a sequential subtract-by-10 engine.
- Scans digits at a divided rate from the 4 MHz system clock.

Parameters:
- SCAN_DIV, 4000: clk cycles per digit slot. Must be >= 2. The default gives a 1 kHz digit rate.
- CW, 12: prescaler counter width. Must satisfy 2^CW >= SCAN_DIV.

Ports:
- clk, input, 1: system clock, 4 MHz.
- rst, input, 1: synchronous reset, active-high.
- minute, input, 7: binary minutes from the timer, 0..127.
- second, input, 6: binary seconds from the timer, 0..63.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- an, output, 4: digit anodes, active-low, one-hot. an[0] is the rightmost digit (seconds ones).
- dp, output, 1: decimal point, active-low.
- ovf, output, 1: high when the last sampled minute > 99 or second > 59.
- upd, output, 1: one-cycle pulse when the displayed digits change.

Behaviour:
- Reset values: prescaler=0, digit index=0, an=4'b1110, seg=encode(0), dp=1, ovf=0, upd=0. Digit registers are all 0, so the display reads "00.00". A conversion is pending.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where count==SCAN_DIV-1.
  - On tick, the digit index advances 0→1→2→3→0. an and seg update in the same edge.
- frame_start = tick while index==3. It sets the pending flag.
- Digit map:
  - Index 0 = seconds ones, 1 = seconds tens, 2 = minute ones, 3 = minute tens.
  - dp=0 only while index==2 (the MM.SS separator); dp=1 otherwise.
- Conversion FSM states: IDLE, CONV, LOAD.
  - IDLE with pending:
    - Clear pending.
    - Snapshot m = (minute>99)?99:minute and s = (second>59)?59:second.
    - Snapshot ovf_n = (minute>99)|(second>59).
    - Clear the tens counters mt and st.
    - Go to CONV.
  - CONV performs one subtraction per cycle:
    - If m>=10: m-=10, mt+=1.
    - Else if s>=10: s-=10, st+=1.
    - Else go to LOAD.
  - LOAD:
    - Copy mt, m, st, s into the four display digit registers and ovf_n into ovf, all in one edge (atomic).
    - upd=1 for this cycle only if any digit register or ovf changed.
    - Go to IDLE.
  - Worst-case latency from the snapshot to display update is 16 cycles (9 + 5 + 1 + 1).
- Simultaneous events:
  - frame_start during CONV or LOAD sets pending. It is serviced on the next IDLE and never dropped.
  - Inputs changing mid-conversion are ignored until the next snapshot.
- Widths:
  - m is 7 bits and s is 6 bits.
  - Tens counters are 4 bits; mt<=9 and st<=5 are guaranteed by the clamps.
- Reset mid-operation: returns to IDLE with pending=1. Digit registers are cleared to 0 and the prescaler restarts.
- Segment encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

Optional Feature:
- Macro: TIME_DISPLAY_LEAD_BLANK_EN.
- Defined: when the minute tens digit register is 0, digit 3 shows blank (seg=1111111). The anode is still driven, so scan timing is unchanged.
- Undefined: the leading zero is shown as "0".

Decomposition:
- Package time_display_pkg holds:
  - the segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - a 2-bit digit-index typedef;
  - the FSM state enum;
  - the clamp constants MIN_MAX=99 and SEC_MAX=59.
- Sub-module bin2bcd_seq: the IDLE/CONV/LOAD converter.
  - Inputs: clk, rst, start, minute, second.
  - Outputs: four BCD digits, ovf, done pulse.
- The top module keeps the prescaler, scan, segment mux and upd generation.

Test Plan (all with SCAN_DIV=4):
- Reset release, minute=0, second=0 → an cycles 1110,1101,1011,0111 every 4 clk; seg=1000000 on all digits; dp=0 only on an=1011; ovf=0.
- minute=25, second=39 held → after the first frame_start plus ≤16 cycles: upd pulses once; digits read 2,5,3,9; seg on an=0111 is 0100100; on an=1110 it is 0010000.
- minute=120, second=63 → digits read 9,9,5,9; ovf=1. Then minute=5, second=7 → next frame shows 0,5,0,7; ovf=0; upd pulses once.
- Same values across two frames → upd stays 0 on the second frame.
- Assert rst during CONV → next cycle seg and digits are 0 and an=1110; conversion restarts after reset deasserts.
- With TIME_DISPLAY_LEAD_BLANK_EN defined and minute=5 → seg=1111111 while an=0111. With minute=15 → seg=1111001 while an=0111.
